// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared encodings for the MEM-stage access unit: SRAM write
//               size codes (matching the legacy defines.v values), FSM state
//               codes and an alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

   // SRAM write-size encodings, identical to the legacy WRITE_* defines
   localparam logic [1:0] WRITE_IDLE = 2'd0;
   localparam logic [1:0] WRITE_BYTE = 2'd1;
   localparam logic [1:0] WRITE_HALF = 2'd2;
   localparam logic [1:0] WRITE_WORD = 2'd3;

   // Access-unit FSM state encodings
   localparam logic [1:0] MAU_IDLE   = 2'd0;
   localparam logic [1:0] MAU_ACCESS = 2'd1;
   localparam logic [1:0] MAU_RESP   = 2'd2;

   // True when a half/word access does not sit on its natural boundary
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      is_misaligned = ((size == WRITE_HALF) && addr_lo[0]) ||
                      ((size == WRITE_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational size/sign extension of little-endian load data.
//               Size 0 (or any non-load) yields zero. Shared with writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o
);

   // Select the significant low bytes and fill the upper bits
   always_comb begin
      data_o = 32'd0;
      case (size_i)
         WRITE_BYTE: data_o = unsigned_i ? {24'd0, data_i[7:0]}
                                         : {{24{data_i[7]}}, data_i[7:0]};
         WRITE_HALF: data_o = unsigned_i ? {16'd0, data_i[15:0]}
                                         : {{16{data_i[15]}}, data_i[15:0]};
         WRITE_WORD: data_o = data_i;
         default:    data_o = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage initiator for a byte-addressed SRAM. Accepts one
//               load/store at a time, holds the SRAM request for
//               1+WAIT_CYCLES cycles, samples read data and returns the
//               extended result on a valid/ready response channel.
//               Optional macro MEM_MISALIGN_CHECK_EN suppresses misaligned
//               half/word accesses and flags them with rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int WAIT_CYCLES = 0,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              MemREAD,
   output logic [1:0]        MemWrite,
   output logic [ADDR_W-1:0] address,
   output logic [31:0]       write_data,
   input  logic [31:0]       read_data
);

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

   logic [1:0]        state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic              mis_q, mis_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              mem_read_q, mem_read_d;
   logic [1:0]        mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] address_q, address_d;
   logic [31:0]       write_data_q, write_data_d;

   logic              misalign;
   logic [1:0]        ext_size;
   logic [31:0]       ext_data;

`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign = is_misaligned(req_size, req_addr[1:0]);
`else
   // Byte-addressed SRAM handles any alignment, so nothing is suppressed
   assign misalign = 1'b0;
`endif

   // Stores, size-0 and suppressed accesses all return zero data
   assign ext_size = (we_q || mis_q) ? WRITE_IDLE : size_q;

   load_extend u_load_extend (
      .size_i     (ext_size),
      .unsigned_i (uns_q),
      .data_i     (read_data),
      .data_o     (ext_data)
   );

   assign req_ready  = (state_q == MAU_IDLE);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_err    = rsp_err_q;
   assign MemREAD    = mem_read_q;
   assign MemWrite   = mem_write_q;
   assign address    = address_q;
   assign write_data = write_data_q;

   // Next-state logic: accept, hold the SRAM request, then respond
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      mis_d        = mis_q;
      cnt_d        = cnt_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      address_d    = address_q;
      write_data_d = write_data_q;
      case (state_q)
         MAU_IDLE: begin
            mem_read_d  = 1'b0;
            mem_write_d = WRITE_IDLE;
            if (req_valid) begin
               we_d         = req_we;
               size_d       = req_size;
               uns_d        = req_unsigned;
               mis_d        = misalign;
               address_d    = req_addr;
               write_data_d = req_wdata;
               mem_read_d   = !req_we && (req_size != WRITE_IDLE) && !misalign;
               mem_write_d  = (req_we && !misalign) ? req_size : WRITE_IDLE;
               cnt_d        = CNT_INIT;
               state_d      = MAU_ACCESS;
            end
         end
         MAU_ACCESS: begin
            if (cnt_q == 4'd0) begin
               rsp_rdata_d = ext_data;
               rsp_err_d   = mis_q;
               rsp_valid_d = 1'b1;
               mem_read_d  = 1'b0;
               mem_write_d = WRITE_IDLE;
               state_d     = MAU_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         MAU_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = MAU_IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = WRITE_IDLE;
            state_d     = MAU_IDLE;
         end
      endcase
   end

   // State registers; reset drops any in-flight access immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= MAU_IDLE;
         we_q         <= 1'b0;
         size_q       <= WRITE_IDLE;
         uns_q        <= 1'b0;
         mis_q        <= 1'b0;
         cnt_q        <= 4'd0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= 32'd0;
         rsp_err_q    <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= WRITE_IDLE;
         address_q    <= '0;
         write_data_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         mis_q        <= mis_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench. Two instances (WAIT_CYCLES 0
//               and 3) share stimulus; sel picks which one is driven and
//               observed. Each has its own little-endian byte SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        mem_clr = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_ready = 1'b0;

   logic        req_valid0, req_valid3, rsp_ready0, rsp_ready3;
   logic        req_ready0, req_ready3, rsp_valid0, rsp_valid3;
   logic [31:0] rsp_rdata0, rsp_rdata3;
   logic        rsp_err0, rsp_err3, MemREAD0, MemREAD3;
   logic [1:0]  MemWrite0, MemWrite3;
   logic [31:0] address0, address3, write_data0, write_data3;
   logic [31:0] read_data0, read_data3;

   logic [7:0]  mem0 [0:1023];
   logic [7:0]  mem3 [0:1023];

   int          checks = 0;
   int          failures = 0;
   int          lat, rd_cnt, wr_cnt;
   logic [1:0]  first_mw;
   logic [31:0] first_addr;

   always #5 clk = ~clk;

   assign req_valid0 = req_valid & ~sel;
   assign req_valid3 = req_valid & sel;
   assign rsp_ready0 = rsp_ready & ~sel;
   assign rsp_ready3 = rsp_ready & sel;

   wire        o_req_ready = sel ? req_ready3 : req_ready0;
   wire        o_rsp_valid = sel ? rsp_valid3 : rsp_valid0;
   wire [31:0] o_rsp_rdata = sel ? rsp_rdata3 : rsp_rdata0;
   wire        o_rsp_err   = sel ? rsp_err3   : rsp_err0;
   wire        o_MemREAD   = sel ? MemREAD3   : MemREAD0;
   wire [1:0]  o_MemWrite  = sel ? MemWrite3  : MemWrite0;
   wire [31:0] o_address   = sel ? address3   : address0;
   wire [31:0] o_wdata     = sel ? write_data3 : write_data0;

   mem_access_unit #(.WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid0),
      .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
      .MemREAD(MemREAD0), .MemWrite(MemWrite0), .address(address0),
      .write_data(write_data0), .read_data(read_data0)
   );

   mem_access_unit #(.WAIT_CYCLES(3), .ADDR_W(32)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
      .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
      .MemREAD(MemREAD3), .MemWrite(MemWrite3), .address(address3),
      .write_data(write_data3), .read_data(read_data3)
   );

   // Combinational little-endian SRAM reads
   assign read_data0 = {mem0[address0[9:0] + 10'd3], mem0[address0[9:0] + 10'd2],
                        mem0[address0[9:0] + 10'd1], mem0[address0[9:0]]};
   assign read_data3 = {mem3[address3[9:0] + 10'd3], mem3[address3[9:0] + 10'd2],
                        mem3[address3[9:0] + 10'd1], mem3[address3[9:0]]};

   // SRAM write ports
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) begin
            mem0[i] <= 8'd0;
            mem3[i] <= 8'd0;
         end
      end else begin
         if (MemWrite0 != 2'd0) begin
            mem0[address0[9:0]] <= write_data0[7:0];
            if (MemWrite0 >= 2'd2) mem0[address0[9:0] + 10'd1] <= write_data0[15:8];
            if (MemWrite0 == 2'd3) begin
               mem0[address0[9:0] + 10'd2] <= write_data0[23:16];
               mem0[address0[9:0] + 10'd3] <= write_data0[31:24];
            end
         end
         if (MemWrite3 != 2'd0) begin
            mem3[address3[9:0]] <= write_data3[7:0];
            if (MemWrite3 >= 2'd2) mem3[address3[9:0] + 10'd1] <= write_data3[15:8];
            if (MemWrite3 == 2'd3) begin
               mem3[address3[9:0] + 10'd2] <= write_data3[23:16];
               mem3[address3[9:0] + 10'd3] <= write_data3[31:24];
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Present a request and return 1 time unit after the accepting edge
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      int guard;
      guard = 0;
      @(negedge clk);
      req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      while (!o_req_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("accept_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      req_valid  = 1'b0;
      first_mw   = o_MemWrite;
      first_addr = o_address;
      rd_cnt     = int'(o_MemREAD);
      wr_cnt     = (o_MemWrite != 2'd0) ? 1 : 0;
   endtask

   // Count cycles until rsp_valid, tallying SRAM strobe cycles on the way
   task automatic wait_rsp();
      lat = 0;
      while (!o_rsp_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         rd_cnt += int'(o_MemREAD);
         wr_cnt += (o_MemWrite != 2'd0) ? 1 : 0;
      end
      if (lat >= 100) check("rsp_timeout", 32'd1, 32'd0);
   endtask

   task automatic ack();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(o_req_ready), 32'd1);
      check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("rst_memread", 32'(o_MemREAD), 32'd0);
      check("rst_memwrite", 32'(o_MemWrite), 32'd0);
      check("rst_address", o_address, 32'd0);
      check("rst_wdata", o_wdata, 32'd0);
      check("rst_rdata", o_rsp_rdata, 32'd0);
      check("rst_err", 32'(o_rsp_err), 32'd0);
      @(negedge clk);
      mem_clr = 1'b0;
      rst_n   = 1'b1;

      // WAIT=0: store word, then load it back
      issue(1'b1, 2'd3, 1'b0, 32'h100, 32'hDEADBEEF);
      check("sw_first_memwrite", 32'(first_mw), 32'd3);
      check("sw_first_addr", first_addr, 32'h100);
      wait_rsp();
      check("sw_latency", lat, 1);
      check("sw_write_cycles", wr_cnt, 1);
      check("sw_rdata", o_rsp_rdata, 32'd0);
      ack();
      check("sw_idle_after", 32'(o_req_ready), 32'd1);
      issue(1'b0, 2'd3, 1'b0, 32'h100, 32'd0);
      wait_rsp();
      check("lw_latency", lat, 1);
      check("lw_read_cycles", rd_cnt, 1);
      check("lw_rdata", o_rsp_rdata, 32'hDEADBEEF);
      check("lw_err", 32'(o_rsp_err), 32'd0);
      ack();

      // Byte store, then signed and unsigned byte loads
      issue(1'b1, 2'd1, 1'b0, 32'h200, 32'h00000080);
      wait_rsp(); ack();
      issue(1'b0, 2'd1, 1'b0, 32'h200, 32'd0);
      wait_rsp();
      check("lb_signed", o_rsp_rdata, 32'hFFFFFF80);
      ack();
      issue(1'b0, 2'd1, 1'b1, 32'h200, 32'd0);
      wait_rsp();
      check("lbu_unsigned", o_rsp_rdata, 32'h00000080);
      ack();

      // Signed half load from 0x102
      issue(1'b0, 2'd2, 1'b0, 32'h102, 32'd0);
      wait_rsp();
      check("lh_signed", o_rsp_rdata, 32'hFFFFDEAD);
      ack();

      // Size-0 request: no strobes, zero data
      issue(1'b0, 2'd0, 1'b0, 32'h100, 32'd0);
      wait_rsp();
      check("sz0_read_cycles", rd_cnt, 0);
      check("sz0_write_cycles", wr_cnt, 0);
      check("sz0_rdata", o_rsp_rdata, 32'd0);
      ack();

      // WAIT=3 instance
      sel = 1'b1;
      issue(1'b1, 2'd3, 1'b0, 32'h100, 32'hDEADBEEF);
      wait_rsp();
      check("w3_sw_latency", lat, 4);
      check("w3_sw_write_cycles", wr_cnt, 4);
      ack();
      issue(1'b0, 2'd2, 1'b0, 32'h102, 32'd0);
      wait_rsp();
      check("w3_lh_latency", lat, 4);
      check("w3_lh_read_cycles", rd_cnt, 4);
      check("w3_lh_rdata", o_rsp_rdata, 32'hFFFFDEAD);
      ack();

      // Backpressure: hold rsp_ready low with a second request pending
      sel = 1'b0;
      issue(1'b0, 2'd3, 1'b0, 32'h100, 32'd0);
      wait_rsp();
      req_we = 1'b0; req_size = 2'd1; req_unsigned = 1'b1;
      req_addr = 32'h200; req_wdata = 32'd0; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
         check("bp_rsp_rdata", o_rsp_rdata, 32'hDEADBEEF);
         check("bp_req_ready", 32'(o_req_ready), 32'd0);
      end
      ack();
      check("bp_hs_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("bp_hs_req_ready", 32'(o_req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("bp_second_accepted", 32'(o_req_ready), 32'd0);
      check("bp_second_memread", 32'(o_MemREAD), 32'd1);
      check("bp_second_addr", o_address, 32'h200);
      rd_cnt = 1; wr_cnt = 0;
      wait_rsp();
      check("bp_second_rdata", o_rsp_rdata, 32'h00000080);
      ack();

      // Asynchronous reset in the middle of a word store
      sel = 1'b1;
      issue(1'b1, 2'd3, 1'b0, 32'h300, 32'h12345678);
      check("rst_mid_pre_memwrite", 32'(first_mw), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_memwrite", 32'(o_MemWrite), 32'd0);
      check("rst_mid_memread", 32'(o_MemREAD), 32'd0);
      check("rst_mid_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("rst_mid_req_ready", 32'(o_req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_post_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("rst_post_req_ready", 32'(o_req_ready), 32'd1);

      // Misaligned word load from 0x101 (bytes BE AD DE 00)
      sel = 1'b0;
      issue(1'b0, 2'd3, 1'b0, 32'h101, 32'd0);
      wait_rsp();
`ifdef MEM_MISALIGN_CHECK_EN
      check("mis_err", 32'(o_rsp_err), 32'd1);
      check("mis_rdata", o_rsp_rdata, 32'd0);
      check("mis_read_cycles", rd_cnt, 0);
`else
      check("mis_err", 32'(o_rsp_err), 32'd0);
      check("mis_rdata", o_rsp_rdata, 32'h00DEADBE);
      check("mis_read_cycles", rd_cnt, 1);
`endif
      check("mis_latency", lat, 1);
      ack();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator for the byte-addressed SRAM. Takes one load/store request at a time from the pipeline and drives the SRAM port (MemREAD, MemWrite, address, write_data).
- Samples the SRAM's combinational read_data, then size-extends and returns load data through a valid/ready response channel.
- Adds configurable wait states so slower memories can be modelled without changing the pipeline.

Parameters:
- WAIT_CYCLES, 0: extra cycles the SRAM request is held before read data is sampled. Range 0..15.
- ADDR_W, 32: width of req_addr and address.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size, using the `WRITE_*` encodings from defines.v: 0 = IDLE/none, 1 = byte, 2 = half, 3 = word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, low bytes significant.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  pipeline accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  access error (only when the optional feature is compiled in).
- MemREAD  out  1  SRAM read strobe.
- MemWrite  out  2  SRAM write size (`WRITE_*` encoding).
- address  out  ADDR_W  SRAM byte address.
- write_data  out  32  SRAM write data.
- read_data  in  32  SRAM combinational read data, little-endian bytes.

Behaviour:
- All outputs are registered except req_ready, which is defined as (state == IDLE).
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, MemREAD 0, MemWrite `WRITE_IDLE`, address 0, write_data 0, wait counter 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On req_valid && req_ready, latch we, size, unsigned and addr.
  - Drive address <= req_addr and write_data <= req_wdata.
  - Drive MemREAD <= !req_we && size != 0.
  - Drive MemWrite <= req_we ? req_size : `WRITE_IDLE`.
  - Load counter with WAIT_CYCLES and go to ACCESS.
  - With req_valid low, stay in IDLE and hold the SRAM outputs idle.
- ACCESS:
  - SRAM signals are held stable for exactly 1+WAIT_CYCLES cycles. The counter decrements each cycle.
  - Repeated store writes of identical data during wait states are permitted and harmless.
  - When the counter is 0:
    - Capture read_data and form rsp_rdata: byte gives read_data[7:0] extended to 32 bits; half gives read_data[15:0] extended; word gives read_data unchanged; store or size 0 gives 0.
    - Set rsp_valid <= 1, MemREAD <= 0, MemWrite <= `WRITE_IDLE`, and go to RESP.
- RESP:
  - Hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready.
  - On rsp_ready, set rsp_valid <= 0 and go to IDLE.
  - A new request can be accepted the cycle after the response handshake, because req_ready is high once the state is IDLE.
- Latency: request accepted at cycle N; rsp_valid is high from cycle N+2+WAIT_CYCLES. Minimum throughput is one access per 3 cycles.
- size = 0 request: no SRAM strobe or write is issued. The request completes normally with rdata 0 and err 0.
- Address arithmetic: no wrap handling; the SRAM owns address+1..+3 decoding.
- Reset asserted mid-operation: immediately return to IDLE and force MemWrite to `WRITE_IDLE` and MemREAD to 0. Any in-flight access or pending response is dropped.
- No request queueing. req_valid with req_ready low is ignored; the requester must hold it.

Optional Feature:
- MEM_MISALIGN_CHECK_EN defined:
  - A half access with addr[0] != 0, or a word access with addr[1:0] != 0, is not issued to the SRAM: MemREAD = 0 and MemWrite = IDLE throughout.
  - The FSM still passes through ACCESS with the same latency.
  - The response has rsp_err = 1 and rsp_rdata = 0.
- Undefined:
  - Misaligned accesses are forwarded unchanged, since the SRAM is byte-addressed.
  - rsp_err is tied to 0.

Decomposition:
- Shared package/defines: the `WRITE_IDLE`/`BYTE`/`HALF`/`WORD` encodings (existing in defines.v), plus new state encodings MAU_IDLE, MAU_ACCESS and MAU_RESP.
- One natural sub-module, load_extend: combinational; inputs size, unsigned, 32-bit data; output 32-bit extended value. It is reusable by the writeback stage.

Test Plan:
- Store word 0xDEADBEEF to 0x100, then load word from 0x100 with WAIT_CYCLES = 0 → MemWrite = 3 for one cycle; rsp_rdata = 0xDEADBEEF at accept+2.
- Store byte 0x80 to 0x200, then load byte from 0x200 signed and unsigned → 0xFFFFFF80 and 0x00000080.
- Load half from 0x102 after the first test, signed → 0xFFFFDEAD; with WAIT_CYCLES = 3, response at accept+5 and MemREAD held for 4 cycles.
- Hold rsp_ready low for 5 cycles → rsp_valid and rsp_rdata stable, req_ready low, and a second req_valid is not accepted until after the handshake.
- Assert rst_n low during ACCESS of a word store → MemWrite reads IDLE before the next clock edge; after reset, rsp_valid = 0 and req_ready = 1.
- With MEM_MISALIGN_CHECK_EN, load word from 0x101 → rsp_err = 1, rsp_rdata = 0, MemREAD never asserted. Without the macro → rsp_err = 0 and the SRAM bytes at 0x101..0x104 are returned.
